// File: rtl/vin_pixel_packer_pkg.sv
// rtl/vin_pixel_packer_pkg.sv - shared types and constants for the video-in pixel packer
package vin_pixel_packer_pkg;

    localparam int VIN_OUT_WIDTH = 64;
    localparam int VIN_CNT_WIDTH = 12;
    localparam int VIN_OUT_BYTES = VIN_OUT_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2,
        ST_DROP  = 2'd3
    } vin_state_t;

    // Number of byte slots in an output word of the given width
    function automatic int vin_out_bytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/vin_pixel_packer.sv
// rtl/vin_pixel_packer.sv - packs receiver Y4 bytes into flagged words for the frame-buffer FIFO
module vin_pixel_packer
    import vin_pixel_packer_pkg::*;
#(
    parameter int OUT_WIDTH = VIN_OUT_WIDTH,
    parameter int CNT_WIDTH = VIN_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 v_vsync,
    input  logic                 v_hsync,
    input  logic                 v_de,
    input  logic [7:0]           v_pixel,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic [CNT_WIDTH-1:0] line_bytes,
    output logic [CNT_WIDTH-1:0] frame_lines,
    output logic                 overflow,
    output logic                 frame_drop
);

    localparam int OUT_BYTES = vin_out_bytes(OUT_WIDTH);
    localparam int IDX_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(OUT_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Registered receiver inputs and their one-clk-older copies for edge detection
    logic       vs_q, vs_q2, hs_q, hs_q2, de_q, de_q2;
    logic [7:0] pix_q;

    vin_state_t             st;
    logic [OUT_WIDTH-1:0]   acc;
    logic [IDX_W-1:0]       byte_idx;
    logic [OUT_WIDTH-1:0]   wbuf;
    logic                   wbuf_full;
    logic                   sof_arm;
    logic [CNT_WIDTH-1:0]   byte_cnt;
    logic [CNT_WIDTH-1:0]   line_cnt;

    logic                   vs_rise, de_rise, de_fall, hs_rise;
    logic                   in_frame, line_end, pack, flush_part;
    logic                   load_req, out_busy, ovf;
    logic [OUT_WIDTH-1:0]   load_data, base_acc, packed_acc;
    logic [IDX_W-1:0]       base_idx;
    logic [CNT_WIDTH-1:0]   base_cnt, cnt_inc, line_inc;

    // Input stage: one register level, then a second copy for edges
    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hs_q  <= 1'b0;
            hs_q2 <= 1'b0;
            de_q  <= 1'b0;
            de_q2 <= 1'b0;
            pix_q <= 8'h00;
        end else begin
            vs_q  <= v_vsync;
            vs_q2 <= vs_q;
            hs_q  <= v_hsync;
            hs_q2 <= hs_q;
            de_q  <= v_de;
            de_q2 <= de_q;
            pix_q <= v_pixel;
        end
    end

    // Edge detection, line-end decision, packing datapath and overflow detection
    always_comb begin
        vs_rise    = vs_q & ~vs_q2;
        de_rise    = de_q & ~de_q2;
        de_fall    = ~de_q & de_q2;
        hs_rise    = hs_q & ~hs_q2 & de_q;
        in_frame   = (st == ST_FRAME) || (st == ST_LINE);
        // hsync inside DE closes the line; the same byte then opens the next one
        line_end   = (st == ST_LINE) && (de_fall || hs_rise);
        pack       = ((st == ST_LINE) && de_q) || ((st == ST_FRAME) && de_rise);
        flush_part = line_end && (byte_idx != '0);
        // A full word waits one clk in wbuf so a DE fall right after it can mark it eol
        load_req   = !vs_rise && in_frame && (wbuf_full || flush_part);
        load_data  = wbuf_full ? wbuf : acc;
        out_busy   = out_valid && !out_ready;
        ovf        = load_req && out_busy;
        base_acc   = line_end ? '0 : acc;
        base_idx   = line_end ? '0 : byte_idx;
        packed_acc = base_acc;
        packed_acc[{base_idx, 3'b000} +: 8] = pix_q;
        base_cnt   = line_end ? '0 : byte_cnt;
        cnt_inc    = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
        line_inc   = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 1'b1;
    end

    // Frame/line FSM with accumulator, counters and the inline output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= ST_IDLE;
            acc         <= '0;
            byte_idx    <= '0;
            wbuf        <= '0;
            wbuf_full   <= 1'b0;
            sof_arm     <= 1'b0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            line_bytes  <= '0;
            frame_lines <= '0;
            overflow    <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            wbuf_full  <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_req && !out_busy) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_sof   <= sof_arm;
                out_eol   <= line_end;
                sof_arm   <= 1'b0;
            end

            if (vs_rise) begin
                // New frame: partial data is discarded without a flush
                if (st != ST_IDLE) begin
                    frame_lines <= line_cnt;
                end
                line_cnt <= '0;
                sof_arm  <= 1'b1;
                st       <= ST_FRAME;
                acc      <= '0;
                byte_idx <= '0;
                byte_cnt <= '0;
            end else begin
                case (st)
                    ST_FRAME, ST_LINE: begin
                        if (ovf) begin
                            overflow   <= 1'b1;
                            frame_drop <= 1'b1;
                            st         <= ST_DROP;
                            acc        <= '0;
                            byte_idx   <= '0;
                            byte_cnt   <= '0;
                        end else begin
                            if (line_end) begin
                                line_bytes <= byte_cnt;
                                line_cnt   <= line_inc;
                                acc        <= '0;
                                byte_idx   <= '0;
                                byte_cnt   <= '0;
                            end
                            if (pack) begin
                                byte_cnt <= cnt_inc;
                                if (base_idx == LAST_IDX) begin
                                    wbuf      <= packed_acc;
                                    wbuf_full <= 1'b1;
                                    acc       <= '0;
                                    byte_idx  <= '0;
                                end else begin
                                    acc      <= packed_acc;
                                    byte_idx <= base_idx + IDX_W'(1);
                                end
                            end
                            if ((st == ST_FRAME) && de_rise) begin
                                st <= ST_LINE;
                            end else if ((st == ST_LINE) && de_fall) begin
                                st <= ST_FRAME;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
